fifo_uart_tx: RTL and testbench

//  Downstream consumer of the 512x8 byte FIFO. Pulls one byte at a time from the FIFO's
//  9-bit output word and serialises it as 8N1 (or 8N2) asynchronous serial on tx.
//  Bit 8 of the FIFO word is the empty flag: 9'h1FF means no byte, 9'h0xx means byte xx.

---
 rtl/fifo_uart_tx.sv | 121 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Serialises bytes pulled from the 512x8 FIFO's 9-bit output word as 8N1/8N2 serial on tx.
// Runs in the FIFO output clock domain; fetch drives the FIFO output_clock_enable.
module fifo_uart_tx #(
   parameter int CLOCK_DIV = 104,
   parameter int STOP_BITS = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [8:0] data_in,
   output logic       fetch,
   output logic       tx,
   output logic       busy
);

   localparam int DIV_W = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIV - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

   state_t           state, next_state;
   logic [DIV_W-1:0] divider, next_divider;
   logic [2:0]       bit_index, next_bit_index;
   logic [7:0]       shift, next_shift;
   logic             next_fetch, next_tx, next_busy;
   logic             div_done;

   assign div_done = (divider == DIV_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         divider   <= '0;
         bit_index <= '0;
         shift     <= '0;
         fetch     <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state     <= next_state;
         divider   <= next_divider;
         bit_index <= next_bit_index;
         shift     <= next_shift;
         fetch     <= next_fetch;
         tx        <= next_tx;
         busy      <= next_busy;
      end
   end

   // fetch is a flop, so the IDLE cycle that carries a fetch pulse was decided by enable
   // on the edge entering it; once a pulse is out the byte must be collected in LOAD.
   always_comb begin
      next_state     = state;
      next_divider   = divider;
      next_bit_index = bit_index;
      next_shift     = shift;
      next_fetch     = 1'b0;
      next_tx        = tx;
      next_busy      = busy;
      case (state)
         IDLE: begin
            if (fetch) next_state = LOAD;
            else       next_fetch = enable;
         end
         LOAD: begin
            if (data_in[8]) begin
               next_state = IDLE;
               next_fetch = enable;
            end else begin
               next_shift   = data_in[7:0];
               next_tx      = 1'b0;
               next_busy    = 1'b1;
               next_divider = '0;
               next_state   = START;
            end
         end
         START: begin
            next_divider = divider + DIV_W'(1);
            if (div_done) begin
               next_divider   = '0;
               next_tx        = shift[0];
               next_bit_index = '0;
               next_state     = DATA;
            end
         end
         DATA: begin
            next_divider = divider + DIV_W'(1);
            if (div_done) begin
               next_divider = '0;
               if (bit_index == 3'd7) begin
                  next_tx        = 1'b1;
                  next_bit_index = '0;
                  next_state     = STOP;
               end else begin
                  next_shift     = shift >> 1;
                  next_tx        = shift[1];
                  next_bit_index = bit_index + 3'd1;
               end
            end
         end
         STOP: begin
            // bit_index doubles as the stop-bit counter
            next_divider = divider + DIV_W'(1);
            if (div_done) begin
               next_divider = '0;
               if (bit_index == STOP_LAST) begin
                  next_busy      = 1'b0;
                  next_bit_index = '0;
                  next_fetch     = enable;
                  next_state     = IDLE;
               end else begin
                  next_bit_index = bit_index + 3'd1;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: two instances (4 clk/bit 1 stop, 2 clk/bit 2 stop)
// fed by behavioural FIFO models; frames are checked against arithmetic frame expectations.
module tb_fifo_uart_tx;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       en0 = 1'b0, en1 = 1'b0;
   logic [8:0] din0 = 9'h1FF, din1 = 9'h1FF;
   logic       tx0, tx1, busy0, busy1, fetch0, fetch1;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   typedef struct {
      int          g;
      logic [7:0]  data;
      logic [10:0] frame;
      int          len;
   } vec_t;

   fifo_uart_tx #(.CLOCK_DIV(4), .STOP_BITS(1)) dut0 (
      .clock(clock), .reset(reset), .enable(en0), .data_in(din0),
      .fetch(fetch0), .tx(tx0), .busy(busy0));

   fifo_uart_tx #(.CLOCK_DIV(2), .STOP_BITS(2)) dut1 (
      .clock(clock), .reset(reset), .enable(en1), .data_in(din1),
      .fetch(fetch1), .tx(tx1), .busy(busy1));

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // FIFO models: the output word changes one cycle after an accepted fetch
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         q0.delete();
         din0 = 9'h1FF;
      end else if (fetch0) begin
         #1;
         din0 = (q0.size() > 0) ? {1'b0, q0.pop_front()} : 9'h1FF;
      end
   end

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         q1.delete();
         din1 = 9'h1FF;
      end else if (fetch1) begin
         #1;
         din1 = (q1.size() > 0) ? {1'b0, q1.pop_front()} : 9'h1FF;
      end
   end

   function automatic int div_of(input int g);
      return (g == 0) ? 4 : 2;
   endfunction

   function automatic int stops_of(input int g);
      return (g == 0) ? 1 : 2;
   endfunction

   function automatic logic tx_of(input int g);
      return (g == 0) ? tx0 : tx1;
   endfunction

   function automatic logic busy_of(input int g);
      return (g == 0) ? busy0 : busy1;
   endfunction

   function automatic logic fetch_of(input int g);
      return (g == 0) ? fetch0 : fetch1;
   endfunction

   // Wire order, index 0 first: start bit, 8 data bits LSB first, then stop bits
   function automatic logic [10:0] make_frame(input int g, input logic [7:0] b);
      logic [10:0] f;
      f      = '0;
      f[8:1] = b;
      for (int i = 9; i < 9 + stops_of(g); i++) f[i] = 1'b1;
      return f;
   endfunction

   task automatic set_en(input int g, input logic v);
      if (g == 0) en0 = v;
      else        en1 = v;
   endtask

   task automatic push(input int g, input logic [7:0] b);
      if (g == 0) q0.push_back(b);
      else        q1.push_back(b);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Waits (bounded) for a start bit, then checks every cycle of the frame
   task automatic applyStimulus(input int g, input logic [10:0] frame, input int exp_len,
                                input int drop_at, output int start_cyc);
      int          div, nb, c, b, wave_errs, fetch_cnt, frame_fetch;
      bit          found;
      logic [10:0] decoded;
      div         = div_of(g);
      nb          = 9 + stops_of(g);
      found       = 1'b0;
      fetch_cnt   = 0;
      frame_fetch = 0;
      wave_errs   = 0;
      decoded     = '0;
      start_cyc   = cyc;
      for (int i = 0; i < 400; i++) begin
         if (tx_of(g) === 1'b0) begin
            found = 1'b1;
            break;
         end
         if (fetch_of(g) === 1'b1) fetch_cnt++;
         @(negedge clock);
      end
      checkOutput("frame_start_seen", 32'(found), 32'd1);
      if (!found) return;
      checkOutput("fetch_before_frame", 32'(fetch_cnt), 32'd1);
      start_cyc = cyc;
      c = 0;
      while (busy_of(g) === 1'b1 && c < 400) begin
         b = c / div;
         if (c == drop_at) set_en(g, 1'b0);
         if (b < nb) begin
            if (tx_of(g) !== frame[b]) wave_errs++;
            if (c % div == div / 2) decoded[b] = tx_of(g);
         end else begin
            wave_errs++;
         end
         if (fetch_of(g) !== 1'b0) frame_fetch++;
         @(negedge clock);
         c++;
      end
      checkOutput("tx_waveform_errs", 32'(wave_errs), 32'd0);
      checkOutput("frame_bits", 32'(decoded), 32'(frame));
      checkOutput("fetch_in_frame", 32'(frame_fetch), 32'd0);
      checkOutput("frame_len", 32'(c), 32'(exp_len));
      checkOutput("tx_idle_after", 32'(tx_of(g)), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t       vecs[6];
      logic [7:0] bytes[6];
      int         st, prev_start, len, same, highs, idle_err, n;
      logic       prev_f, f;
      bit         found;

      vecs[0] = '{0, 8'h55, 11'h2AA, 40};
      vecs[1] = '{0, 8'h00, 11'h200, 40};
      vecs[2] = '{0, 8'h80, 11'h300, 40};
      vecs[3] = '{1, 8'hA5, 11'h74A, 22};
      vecs[4] = '{1, 8'hFF, 11'h7FE, 22};
      vecs[5] = '{1, 8'h01, 11'h602, 22};

      // Reset held with arbitrary enables
      en0 = 1'($urandom);
      en1 = 1'($urandom);
      repeat (5) @(negedge clock);
      for (int g = 0; g < 2; g++) begin
         checkOutput("reset_tx", 32'(tx_of(g)), 32'd1);
         checkOutput("reset_fetch", 32'(fetch_of(g)), 32'd0);
         checkOutput("reset_busy", 32'(busy_of(g)), 32'd0);
      end
      en0 = 1'b0;
      en1 = 1'b0;
      reset = 1'b1;
      idle_err = 0;
      repeat (100) begin
         @(negedge clock);
         if (tx0 !== 1'b1 || fetch0 !== 1'b0 || busy0 !== 1'b0) idle_err++;
         if (tx1 !== 1'b1 || fetch1 !== 1'b0 || busy1 !== 1'b0) idle_err++;
      end
      checkOutput("idle_after_release", 32'(idle_err), 32'd0);

      // Single-frame vector table
      foreach (vecs[i]) begin
         push(vecs[i].g, vecs[i].data);
         set_en(vecs[i].g, 1'b1);
         applyStimulus(vecs[i].g, vecs[i].frame, vecs[i].len, 0, st);
         n = 0;
         repeat (10) begin
            @(negedge clock);
            if (fetch_of(vecs[i].g) !== 1'b0) n++;
         end
         checkOutput("idle_no_fetch", 32'(n), 32'd0);
      end

      // Back-to-back 0x00, 0xFF then random bytes, followed by an empty FIFO
      for (int g = 0; g < 2; g++) begin
         bytes[0] = 8'h00;
         bytes[1] = 8'hFF;
         for (int k = 2; k < 6; k++) bytes[k] = 8'($urandom);
         for (int k = 0; k < 6; k++) push(g, bytes[k]);
         len = (9 + stops_of(g)) * div_of(g);
         prev_start = 0;
         set_en(g, 1'b1);
         for (int k = 0; k < 6; k++) begin
            applyStimulus(g, make_frame(g, bytes[k]), len, -1, st);
            if (k > 0) checkOutput("start_spacing", 32'(st - prev_start), 32'(len + 2));
            prev_start = st;
         end
         prev_f = fetch_of(g);
         same = 0;
         highs = 0;
         idle_err = 0;
         repeat (12) begin
            @(negedge clock);
            f = fetch_of(g);
            if (f === prev_f) same++;
            if (f === 1'b1) highs++;
            if (tx_of(g) !== 1'b1 || busy_of(g) !== 1'b0) idle_err++;
            prev_f = f;
         end
         checkOutput("empty_fetch_toggle", 32'(same), 32'd0);
         checkOutput("empty_fetch_count", 32'(highs), 32'd6);
         checkOutput("empty_idle", 32'(idle_err), 32'd0);
         set_en(g, 1'b0);
         repeat (4) @(negedge clock);
      end

      // enable dropped during data bit 3: frame completes, then no more fetches
      push(0, 8'h96);
      push(0, 8'h3C);
      set_en(0, 1'b1);
      applyStimulus(0, make_frame(0, 8'h96), 40, 17, st);
      n = 0;
      repeat (30) begin
         @(negedge clock);
         if (fetch0 !== 1'b0 || tx0 !== 1'b1) n++;
      end
      checkOutput("no_fetch_after_disable", 32'(n), 32'd0);

      // Reset pulse during data bit 3 of the next frame
      set_en(0, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (tx0 === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("second_frame_start", 32'(found), 32'd1);
      repeat (17) @(negedge clock);
      #1 reset = 1'b0;
      #1;
      checkOutput("async_reset_tx", 32'(tx0), 32'd1);
      checkOutput("async_reset_busy", 32'(busy0), 32'd0);
      checkOutput("async_reset_fetch", 32'(fetch0), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      push(0, 8'h5A);
      applyStimulus(0, make_frame(0, 8'h5A), 40, 0, st);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
